// File: rtl/aexm_pkg.sv
// aexm_pkg: shared constants and the fetch entry type for the AEXM front end.
package aexm_pkg;
  localparam logic [31:0] AEXM_NOP = 32'h8000_0000;
  localparam logic [5:0] OPC_BSF0 = 6'o21;
  localparam logic [5:0] OPC_BSF1 = 6'o31;
  localparam logic [5:0] OPC_IMM  = 6'o54;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } aexm_fetch_t;
endpackage

// File: rtl/aexm_fetch_buf_mem.sv
// aexm_fetch_buf_mem: DEPTH x 64 entry storage, one write port, one asynchronous read port.
module aexm_fetch_buf_mem
  import aexm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  aexm_fetch_t   wdata,
  input  logic [AW-1:0] raddr,
  output aexm_fetch_t   rdata
);
  aexm_fetch_t mem_q [DEPTH];
  always_ff @(posedge gclk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/aexm_fetch_buf.sv
// aexm_fetch_buf: instruction fetch queue feeding decode, with barrel-shift hold and flush.
// Define AEXM_FETCH_BUF_BYPASS_EN to let an offer reach decode in the same cycle when empty.
module aexm_fetch_buf
  import aexm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          ic_valid,
  input  logic [31:0]   ic_inst,
  input  logic [31:0]   ic_pc,
  output logic          ic_ready,
  input  logic          d_en,
  input  logic          fSTALL,
  input  logic          flush,
  output logic [31:0]   dINST,
  output logic [31:0]   dPC,
  output logic          dVALID,
  output logic [AW:0]   fb_count
);
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          hold_q, hold_d;
  logic          byp, push, pop, wr_en, rd_adv;
  aexm_fetch_t   head;
  aexm_fetch_buf_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .gclk  (gclk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({ic_inst, ic_pc}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );
  assign ic_ready = grst_n & (count_q != (AW+1)'(DEPTH));
  assign fb_count = count_q;
  always_comb begin
`ifdef AEXM_FETCH_BUF_BYPASS_EN
    byp = grst_n & (count_q == '0) & ic_valid & ~flush;
`else
    byp = 1'b0;
`endif
    dVALID = (count_q != '0) | byp;
    dINST = !dVALID ? AEXM_NOP : byp ? ic_inst : head.inst;
    dPC = !dVALID ? 32'h0 : byp ? ic_pc : head.pc;
    push = ic_valid & ic_ready & ~flush;
    pop = dVALID & d_en & ~flush & (~fSTALL | hold_q);
    // a bypassed word consumed in the same cycle never touches storage
    wr_en = push & ~(byp & pop);
    rd_adv = pop & ~byp;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_adv);
    count_d = flush ? '0 : count_q + (AW+1)'(wr_en) - (AW+1)'(rd_adv);
    hold_d = (flush | pop) ? 1'b0 : (dVALID & d_en & fSTALL) ? 1'b1 : hold_q;
  end
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_aexm_fetch_buf.sv
// tb_aexm_fetch_buf: directed scenarios plus random traffic against a queue-based model.
module tb_aexm_fetch_buf;
  import aexm_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  logic gclk = 0, grst_n = 0, ic_valid = 0, d_en = 0, flush = 0, stall_en = 0;
  logic [31:0] ic_inst = 0, ic_pc = 0;
  logic ic_ready, dVALID, fSTALL;
  logic [31:0] dINST, dPC;
  logic [AW:0] fb_count;
  int checks = 0, errors = 0;
  aexm_fetch_t fq[$];
  logic mh = 0;
  logic s_iv, s_den, s_fl, s_fs;
  logic [31:0] s_inst, s_pc;
  bit log_en = 0;
  logic [31:0] seen[$];

  aexm_fetch_buf #(.DEPTH(DEPTH)) dut (
    .gclk(gclk), .grst_n(grst_n), .ic_valid(ic_valid), .ic_inst(ic_inst), .ic_pc(ic_pc),
    .ic_ready(ic_ready), .d_en(d_en), .fSTALL(fSTALL), .flush(flush), .dINST(dINST),
    .dPC(dPC), .dVALID(dVALID), .fb_count(fb_count)
  );

  always #5 gclk = ~gclk;
  assign fSTALL = stall_en & dVALID & (dINST[31:26] == OPC_BSF0 || dINST[31:26] == OPC_BSF1);

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit byp_now();
`ifdef AEXM_FETCH_BUF_BYPASS_EN
    return fq.size() == 0 && ic_valid && !flush && grst_n;
`else
    return 0;
`endif
  endfunction

  always @(negedge gclk) begin
    bit bp;
    bp = byp_now();
    chk("dVALID", 32'(dVALID), 32'(fq.size() > 0 || bp));
    chk("dINST", dINST, fq.size() > 0 ? fq[0].inst : bp ? ic_inst : AEXM_NOP);
    chk("dPC", dPC, fq.size() > 0 ? fq[0].pc : bp ? ic_pc : 32'h0);
    chk("fb_count", 32'(fb_count), 32'(fq.size()));
    chk("ic_ready", 32'(ic_ready), 32'(grst_n && fq.size() < DEPTH));
    s_iv = ic_valid; s_den = d_en; s_fl = flush; s_fs = fSTALL;
    s_inst = ic_inst; s_pc = ic_pc;
    if (log_en && dVALID) seen.push_back(dPC);
  end

  always @(posedge gclk or negedge grst_n) begin
    bit bp, hv, pop, acc;
    if (!grst_n) begin
      fq.delete();
      mh = 0;
    end else begin
`ifdef AEXM_FETCH_BUF_BYPASS_EN
      bp = fq.size() == 0 && s_iv && !s_fl;
`else
      bp = 0;
`endif
      hv = fq.size() > 0 || bp;
      pop = hv && s_den && !s_fl && (!s_fs || mh);
      acc = s_iv && fq.size() < DEPTH && !s_fl;
      if (s_fl) begin
        fq.delete();
        mh = 0;
      end else begin
        if (!(bp && pop)) begin
          if (pop) void'(fq.pop_front());
          if (acc) fq.push_back('{s_inst, s_pc});
        end
        mh = pop ? 1'b0 : (hv && s_den && s_fs) ? 1'b1 : mh;
      end
    end
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle_drain();
    tick();
    ic_valid = 0; flush = 0; stall_en = 0; d_en = 1;
    repeat (6) tick();
    d_en = 0;
  endtask

  task automatic push(logic [31:0] inst, logic [31:0] pc);
    tick();
    ic_valid = 1; ic_inst = inst; ic_pc = pc;
  endtask

  initial begin
    logic [5:0] opc;
    repeat (3) tick();
    grst_n = 1;
    #1;
    chk("rst_dVALID", 32'(dVALID), 32'h0);
    chk("rst_dINST", dINST, 32'h8000_0000);
    chk("rst_ready", 32'(ic_ready), 32'h1);
    chk("rst_count", 32'(fb_count), 32'h0);
    // fill then drain
    for (int i = 0; i < 4; i++) push(32'hA000_0000 | 32'(i), 32'h100 + 32'(4 * i));
    tick();
    ic_valid = 0;
    #1;
    chk("full_count", 32'(fb_count), 32'h4);
    chk("full_ready", 32'(ic_ready), 32'h0);
    d_en = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", dPC, 32'h100 + 32'(4 * i));
      chk("drain_valid", 32'(dVALID), 32'h1);
      tick();
      #1;
    end
    chk("drain_empty_v", 32'(dVALID), 32'h0);
    chk("drain_empty_i", dINST, 32'h8000_0000);
    // barrel-shift hold
    idle_drain();
    d_en = 1; stall_en = 1; seen.delete(); log_en = 1;
    push(32'h4400_0000, 32'h400);
    push(32'h8000_0001, 32'h404);
    tick();
    ic_valid = 0;
    repeat (4) tick();
    log_en = 0;
    chk("bsf_seen_n", 32'(seen.size()), 32'h3);
    if (seen.size() >= 3) begin
      chk("bsf_seen0", seen[0], 32'h400);
      chk("bsf_seen1", seen[1], 32'h400);
      chk("bsf_seen2", seen[2], 32'h404);
    end
    // flush with simultaneous push
    idle_drain();
    for (int i = 0; i < 3; i++) push(32'h1000_0000, 32'h180 + 32'(4 * i));
    tick();
    flush = 1; ic_valid = 1; ic_pc = 32'h200; ic_inst = 32'h2000_0000;
    tick();
    flush = 0; ic_valid = 0;
    #1;
    chk("flush_count", 32'(fb_count), 32'h0);
    chk("flush_valid", 32'(dVALID), 32'h0);
    d_en = 1; seen.delete(); log_en = 1;
    repeat (4) tick();
    log_en = 0;
    chk("flush_no200", 32'(seen.size()), 32'h0);
    // flush during hold
    idle_drain();
    stall_en = 1;
    push(32'h4400_0010, 32'h500);
    tick();
    ic_valid = 0; d_en = 1;
    tick();
    flush = 1;
    tick();
    flush = 0; seen.delete(); log_en = 1;
    push(32'h6400_0000, 32'h600);
    push(32'h8000_0002, 32'h604);
    tick();
    ic_valid = 0;
    repeat (4) tick();
    log_en = 0;
    chk("fh_seen_n", 32'(seen.size()), 32'h3);
    if (seen.size() >= 3) begin
      chk("fh_seen0", seen[0], 32'h600);
      chk("fh_seen1", seen[1], 32'h600);
      chk("fh_seen2", seen[2], 32'h604);
    end
    // async reset mid-stream
    idle_drain();
    push(32'h1111_0000, 32'h700);
    push(32'h1111_0001, 32'h704);
    tick();
    ic_valid = 0;
    @(posedge gclk);
    #2 grst_n = 0;
    #1;
    chk("ar_valid", 32'(dVALID), 32'h0);
    chk("ar_inst", dINST, 32'h8000_0000);
    chk("ar_pc", dPC, 32'h0);
    chk("ar_ready", 32'(ic_ready), 32'h0);
    #1 grst_n = 1;
    #2;
    chk("ar_rel_ready", 32'(ic_ready), 32'h1);
    chk("ar_rel_count", 32'(fb_count), 32'h0);
    // same-cycle bypass versus one-cycle latency
    idle_drain();
    tick();
    d_en = 1; ic_valid = 1; ic_pc = 32'h300; ic_inst = 32'h1234_5678;
    #1;
`ifdef AEXM_FETCH_BUF_BYPASS_EN
    chk("byp_pc", dPC, 32'h300);
    chk("byp_valid", 32'(dVALID), 32'h1);
`else
    chk("nobyp_valid", 32'(dVALID), 32'h0);
`endif
    tick();
    ic_valid = 0;
    #1;
`ifdef AEXM_FETCH_BUF_BYPASS_EN
    chk("byp_count", 32'(fb_count), 32'h0);
    chk("byp_after_v", 32'(dVALID), 32'h0);
`else
    chk("nobyp_pc", dPC, 32'h300);
    chk("nobyp_valid2", 32'(dVALID), 32'h1);
`endif
    // random traffic
    idle_drain();
    for (int i = 0; i < 3000; i++) begin
      tick();
      ic_valid = ($urandom % 4) != 0;
      d_en = ($urandom % 4) != 0;
      flush = ($urandom % 32) == 0;
      stall_en = $urandom % 2;
      opc = ($urandom % 4 == 0) ? (($urandom % 2) ? OPC_BSF0 : OPC_BSF1) : 6'($urandom);
      ic_inst = {opc, 26'($urandom)};
      ic_pc = $urandom;
    end
    idle_drain();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aexm_fetch_buf.md
# aexm_fetch_buf

Instruction fetch buffer between the instruction-cache read port and the decode/control stage. It queues fetched instruction/PC pairs and presents the head entry as `dINST`/`dPC` to decode. It holds the head for one extra cycle on a two-cycle barrel-shift instruction (`fSTALL`), discards all queued entries on a branch flush, and presents a NOP bubble whenever it is empty.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: pointer index width (derived; not overridden).

Ports:
- `gclk` in 1: clock. One clock domain.
- `grst_n` in 1: reset, asynchronous, active-low.
- `ic_valid` in 1: cache offers an instruction this cycle.
- `ic_inst` in 32: offered instruction word.
- `ic_pc` in 32: address of the offered instruction.
- `ic_ready` out 1: buffer accepts the offer. Equals `grst_n & (count != DEPTH)`.
- `d_en` in 1: decode stage advances this cycle.
- `fSTALL` in 1: current `dINST` is a two-cycle instruction, driven combinationally by control from `dINST`.
- `flush` in 1: branch taken; discard every queued entry.
- `dINST` out 32: head instruction, or NOP `32'h8000_0000` when empty.
- `dPC` out 32: head PC, or 0 when empty.
- `dVALID` out 1: head entry is real.
- `fb_count` out AW+1: current occupancy.

## Operation
- Circular queue with `wr_ptr` and `rd_ptr` (each AW bits, wrap modulo DEPTH) and `count` (AW+1 bits, range 0..DEPTH).
- **Push:** `ic_valid & ic_ready & !flush`. Writes at `wr_ptr`, then increments `wr_ptr`.
- **Hold flag** `bsf_hold`:
  - Set on `dVALID & d_en & fSTALL & !bsf_hold`.
  - Cleared on pop or flush.
- **Pop:** `dVALID & d_en & !flush & (!fSTALL | bsf_hold)`. Increments `rd_ptr`.
  - A `fSTALL` instruction therefore occupies decode for exactly two `d_en` cycles.
- **Simultaneous push and pop:** `count` is unchanged. Both pointers advance.
- **Push when full:** impossible because `ic_ready` is low. A pop in the same cycle does not open a slot until the next cycle.
- **Pop when empty:** impossible because `dVALID` is low.
- **`d_en` low:** no pop, and `bsf_hold` is unchanged. The head stays stable.
- **Flush:** synchronous. Next cycle `count` = 0, pointers = 0, `bsf_hold` = 0.
  - A push offered in the flush cycle is dropped (it belongs to the old stream).
  - Flush overrides pop and hold.
- **Reset (any time, including mid-operation):** `count` = 0, pointers = 0, `bsf_hold` = 0. Outputs go to `dINST` = NOP, `dPC` = 0, `dVALID` = 0, `fb_count` = 0, `ic_ready` = 0 while `grst_n` is low. Storage contents are don't-care.
- No arithmetic beyond pointer/count increment. Pointers wrap naturally at DEPTH.

## Timing
- Head outputs are a combinational read of the storage at `rd_ptr`, gated by `dVALID`. They change only on a clock edge, except in the bypass case (see Configuration).
- Push-to-head latency is 1 cycle without bypass.
- `ic_ready` depends only on registered `count` and `grst_n`. There is no combinational path from `d_en`, `fSTALL` or `flush` to `ic_ready`.
- The `fSTALL` → pop path is combinational into the next-state logic only. There is no loop to `dINST`.
- Throughput: one instruction per cycle in steady state. A `fSTALL` instruction costs one bubble.

## Configuration
- **`AEXM_FETCH_BUF_BYPASS_EN` defined:** when `count` = 0 and `ic_valid` is high and `flush` is low, `dINST`/`dPC` = `ic_inst`/`ic_pc` and `dVALID` = 1 in the same cycle.
  - If that entry is popped in the same cycle (no `fSTALL`), it is not written and `count` stays 0.
  - Otherwise it is written normally.
  - Push-to-head latency is 0 cycles.
- **Not defined:** no bypass. Latency is 1 cycle, and `ic_*` never reaches `d*` combinationally.

## Structure
- Shared package `aexm_pkg`:
  - `AEXM_NOP` (`32'h8000_0000`).
  - Opcode constants (`OPC_BSF0` `6'o21`, `OPC_BSF1` `6'o31`, `OPC_IMM` `6'o54`).
  - `aexm_fetch_t` struct `{inst[31:0], pc[31:0]}`.
- Sub-module `aexm_fetch_buf_mem`: DEPTH×64 register array with one write port and one asynchronous read port. Pointer, count and hold logic stay in the top module.

## Test plan
- **Fill/drain:** push 4 words (PC 0x100..0x10C) with `d_en` low → `ic_ready` 0 and `fb_count` 4. Then `d_en` high → words emerge in order, one per cycle, then NOP with `dVALID` 0.
- **Barrel-shift hold:** push `32'h4400_0000` (opcode `6'o21`) then `32'h8000_0001` with `d_en` high and `fSTALL` = 1 for the first word → first word is presented for 2 cycles, second on the 3rd cycle.
- **Flush with simultaneous push:** 3 queued entries, `flush` and `ic_valid` (PC 0x200) in the same cycle → next cycle `fb_count` 0, `dVALID` 0, and PC 0x200 never appears.
- **Flush during hold:** `bsf_hold` set, then `flush` → hold cleared. The next pushed `fSTALL` word again takes 2 cycles.
- **Async reset mid-stream:** with 2 entries queued, pulse `grst_n` low between edges → outputs immediately read NOP/0/0, `ic_ready` 0. After release, `ic_ready` 1 and `fb_count` 0.
- **Bypass (macro on):** empty buffer, `ic_valid` with PC 0x300 and `d_en` high → `dPC` 0x300 and `dVALID` 1 in the same cycle, and `fb_count` stays 0. With the macro off → `dPC` 0x300 appears the next cycle.
